// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
// Provides XLEN, the NOP encoding and the buffered fetch entry {pc, inst}.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with push/pop/flush.
// Ports: push/push_data in; pop/flush in; valid/head/count out (head from flops).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output logic                   valid,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam fetch_entry_t RST_ENTRY = '{pc: '0, inst: NOP_INST};

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(push)
                        - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_ENTRY;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid = (count_q != '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage; PC, imem req/gnt/rvalid, response FIFO, redirect.
// Ports: imem_* to memory, redirect_* in, inst_* to decode, misalign_err (FETCH_MISALIGN_TRAP_EN).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic            misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            started_q;
  logic            err_q, err_d;

  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic [XLEN-1:0] redir_pc;
  logic            gnt_fire;
  logic            push;
  logic            pop;
  logic            fifo_valid;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // Stale (to-be-dropped) responses never land in the FIFO,
  // so they give their credit back immediately.
  assign used = {1'b0, count} + {1'b0, inflight_q}
              - {1'b0, drop_q};

  assign imem_req  = started_q && !err_q
                  && (used < DEPTH_W);
  assign imem_addr = fetch_pc_q;
  assign gnt_fire  = imem_req && imem_gnt;
  assign redir_pc  = redirect_pc & ~32'h3;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    push       = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    err_d      = err_q;
`else
    err_d      = 1'b0;
`endif
    inflight_d = inflight_q + CW'(gnt_fire)
                            - CW'(imem_rvalid);
    if (gnt_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (imem_rvalid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - CW'(1);
      end else begin
        push     = 1'b1;
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
    end
    // Everything still outstanding after this cycle is stale.
    if (redirect_valid) begin
      push       = 1'b0;
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      drop_d     = inflight_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_d      = |redirect_pc[1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      started_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      started_q  <= 1'b1;
      err_q      <= err_d;
    end
  end

  assign push_data = '{pc: rsp_pc_q, inst: imem_rdata};
  assign pop       = fifo_valid && inst_ready;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .valid    (fifo_valid),
    .head     (head),
    .count    (count)
  );

  assign inst_valid   = fifo_valid;
  assign inst         = head.inst;
  assign inst_pc      = head.pc;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order imem model.
// Covers reset, streaming, backpressure, redirects, PC wrap, gnt stalls, misalign.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        misalign_err;

  fetch_unit #(
    .RESET_PC(RST_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    return a ^ 32'h5a5a_0003;
  endfunction

  // imem model: in-order, fixed latency, optional random gnt
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        q[$];
  int          cyc = 0;
  int          mem_lat = 1;
  bit          gnt_rand = 1'b0;
  int          gnt_cnt = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr;

  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend_addr   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        pend        = 1'b0;
      end else begin
        if (pend) begin
          check("addr_hold", imem_addr, pend_addr);
          check("req_hold", 32'(imem_req), 32'd1);
        end
        imem_rvalid = 1'b0;
        if (q.size() > 0 && q[0].due <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(q[0].addr);
          void'(q.pop_front());
        end
        imem_gnt = gnt_rand
                 ? ($urandom_range(0, 1) == 1)
                 : 1'b1;
        if (imem_req && imem_gnt) begin
          q.push_back('{addr: imem_addr,
                        due: cyc + mem_lat});
          gnt_cnt++;
        end
        pend      = imem_req && !imem_gnt
                 && !redirect_valid;
        pend_addr = imem_addr;
      end
    end
  end

  // decode-side scoreboard: every accepted word in PC order
  logic [31:0] exp_pc;
  int          n_hs = 0;

  initial begin
    exp_pc = RST_PC;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_pc = RST_PC;
      end else begin
        if (inst_valid && inst_ready) begin
          check("inst_pc", inst_pc, exp_pc);
          check("inst_word", inst, mem_word(exp_pc));
          exp_pc += 32'd4;
          n_hs++;
        end
        if (redirect_valid) begin
          exp_pc = redirect_pc & ~32'h3;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_hs(input string tag, input int n);
    int start;
    int k;
    start = n_hs;
    k = 0;
    while ((n_hs - start) < n && k < 300) begin
      step(1);
      k++;
    end
    check(tag, 32'((n_hs - start) >= n), 32'd1);
  endtask

  task automatic wait_cond_lat1();
    int k;
    k = 0;
    while (!(imem_req && q.size() > 0) && k < 40) begin
      step(1);
      k++;
    end
    check("grant_rsp_setup", 32'(k < 40), 32'd1);
  endtask

  task automatic wait_two_inflight();
    int k;
    k = 0;
    while (q.size() != 2 && k < 40) begin
      step(1);
      k++;
    end
    check("two_inflight_setup", 32'(k < 40), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2 rst_n = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_err", 32'(misalign_err), 32'd0);

    // startup latency and back-to-back first requests
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h100);
    @(negedge clk);
    check("second_req", 32'(imem_req), 32'd1);
    check("second_addr", imem_addr, 32'h104);
    @(negedge clk);
    check("first_valid", 32'(inst_valid), 32'd1);
    check("first_inst_pc", inst_pc, 32'h100);
    step(1);
    wait_hs("stream_hs", 8);

    // mid-operation reset, then decode backpressure
    inst_ready = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("async_rst_req", 32'(imem_req), 32'd0);
    check("async_rst_valid", 32'(inst_valid), 32'd0);
    check("async_rst_inst", inst, 32'h0000_0013);
    step(1);
    rst_n = 1'b1;
    begin
      int g0;
      g0 = gnt_cnt;
      step(4);
      check("hold_head_early", inst_pc, 32'h100);
      step(8);
      check("hold_grants", 32'(gnt_cnt - g0), 32'(DEPTH));
    end
    check("hold_req_off", 32'(imem_req), 32'd0);
    check("hold_valid", 32'(inst_valid), 32'd1);
    check("hold_head_late", inst_pc, 32'h100);
    check("hold_word", inst, mem_word(32'h100));
    inst_ready = 1'b1;
    wait_hs("hold_release_hs", 4);

    // redirect with two requests outstanding
    mem_lat = 3;
    wait_two_inflight();
    do_redirect(32'h200);
    check("redir_valid_low", 32'(inst_valid), 32'd0);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h200);
    wait_hs("redir_hs", 4);

    // redirect coinciding with a grant and a response
    mem_lat = 1;
    step(4);
    wait_cond_lat1();
    do_redirect(32'h280);
    check("same_cyc_valid_low", 32'(inst_valid), 32'd0);
    check("same_cyc_req", 32'(imem_req), 32'd1);
    check("same_cyc_addr", imem_addr, 32'h280);
    wait_hs("same_cyc_hs", 4);

    // 32-bit PC wrap
    do_redirect(32'hFFFF_FFF8);
    check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    wait_hs("wrap_hs", 5);

    // latency 3 with random grant stalls
    mem_lat  = 3;
    gnt_rand = 1'b1;
    wait_hs("stall_hs", 20);
    gnt_rand = 1'b0;
    mem_lat  = 1;
    step(6);

`ifdef FETCH_MISALIGN_TRAP_EN
    do_redirect(32'h202);
    check("mis_err_set", 32'(misalign_err), 32'd1);
    check("mis_req_off", 32'(imem_req), 32'd0);
    check("mis_valid_low", 32'(inst_valid), 32'd0);
    step(5);
    check("mis_req_still_off", 32'(imem_req), 32'd0);
    check("mis_err_sticky", 32'(misalign_err), 32'd1);
    check("mis_no_valid", 32'(inst_valid), 32'd0);
    do_redirect(32'h300);
    check("mis_err_clear", 32'(misalign_err), 32'd0);
    check("mis_resume_req", 32'(imem_req), 32'd1);
    check("mis_resume_addr", imem_addr, 32'h300);
    wait_hs("mis_resume_hs", 3);
`else
    do_redirect(32'h202);
    check("unaligned_err", 32'(misalign_err), 32'd0);
    check("unaligned_req", 32'(imem_req), 32'd1);
    check("unaligned_addr", imem_addr, 32'h200);
    wait_hs("unaligned_hs", 3);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
